// File: rtl/baccarat_pkg.sv
// Shared types, thresholds and card/score helpers for the baccarat controller.
package baccarat_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_P1,
    S_D1,
    S_P2,
    S_D2,
    S_EVAL,
    S_P3,
    S_DDEC,
    S_D3,
    S_RESULT,
    S_DONE
  } state_t;

  localparam logic [3:0] NATURAL_MIN = 4'd8;
  localparam logic [3:0] DRAW_MAX    = 4'd5;

  // Face cards and tens count as zero; rank 0 (no card) also maps to zero.
  function automatic logic [3:0] card_value(input logic [31:0] rank);
    return (rank >= 32'd10) ? 4'd0 : rank[3:0];
  endfunction

  function automatic logic [3:0] clamp9(input logic [31:0] score);
    return (score > 32'd9) ? 4'd9 : score[3:0];
  endfunction

endpackage

// File: rtl/dealer_draw_rule.sv
// Dealer third-card tableau: given the dealer score and the player's third-card
// value, decides whether the dealer draws.
module dealer_draw_rule (
  input  logic [3:0] dscore,
  input  logic [3:0] card_val,
  output logic       draw
);

  always_comb begin
    draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: draw = 1'b1;
      4'd3:             draw = (card_val != 4'd8);
      4'd4:             draw = (card_val >= 4'd2) && (card_val <= 4'd7);
      4'd5:             draw = (card_val >= 4'd4) && (card_val <= 4'd7);
      4'd6:             draw = (card_val >= 4'd6) && (card_val <= 4'd7);
      default:          draw = 1'b0;
    endcase
  end

endmodule

// File: rtl/baccarat_ctrl.sv
// Baccarat round sequencer: issues card-load strobes, applies drawing rules to
// the datapath scores and latches the win lights at the end of the round.
module baccarat_ctrl
  import baccarat_pkg::*;
#(
  parameter int SCORE_W = 4,
  parameter int CARD_W  = 4
) (
  input  logic               slow_clock,
  input  logic               resetb,
  input  logic [SCORE_W-1:0] pscore,
  input  logic [SCORE_W-1:0] dscore,
  input  logic [CARD_W-1:0]  pcard3,
  output logic               load_pcard1,
  output logic               load_pcard2,
  output logic               load_pcard3,
  output logic               load_dcard1,
  output logic               load_dcard2,
  output logic               load_dcard3,
  output logic               player_win_light,
  output logic               dealer_win_light,
  output logic               done
);

  state_t     state_reg;
  state_t     state_next;
  logic       player_light_reg;
  logic       dealer_light_reg;
  logic [3:0] pscore_c;
  logic [3:0] dscore_c;
  logic [3:0] pcard3_val;
  logic       dealer_draw;

  assign pscore_c   = clamp9(32'(pscore));
  assign dscore_c   = clamp9(32'(dscore));
  assign pcard3_val = card_value(32'(pcard3));

  dealer_draw_rule u_dealer_draw_rule (
    .dscore   (dscore_c),
    .card_val (pcard3_val),
    .draw     (dealer_draw)
  );

  always_ff @(posedge slow_clock) begin
    if (resetb) begin
      state_reg        <= S_IDLE;
      player_light_reg <= 1'b0;
      dealer_light_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      // Scores are final in S_RESULT; the lights land with the move to S_DONE.
      if (state_reg == S_RESULT) begin
        player_light_reg <= (pscore_c >= dscore_c);
        dealer_light_reg <= (dscore_c >= pscore_c);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   state_next = S_P1;
      S_P1:     state_next = S_D1;
      S_D1:     state_next = S_P2;
      S_P2:     state_next = S_D2;
      S_D2:     state_next = S_EVAL;
      S_EVAL: begin
        if ((pscore_c >= NATURAL_MIN) || (dscore_c >= NATURAL_MIN))
          state_next = S_RESULT;
        else if (pscore_c <= DRAW_MAX)
          state_next = S_P3;
        else if (dscore_c <= DRAW_MAX)
          state_next = S_D3;
        else
          state_next = S_RESULT;
      end
      S_P3:     state_next = S_DDEC;
      S_DDEC:   state_next = dealer_draw ? S_D3 : S_RESULT;
      S_D3:     state_next = S_RESULT;
      S_RESULT: state_next = S_DONE;
      S_DONE:   state_next = S_DONE;
      default:  state_next = S_IDLE;
    endcase
  end

  assign load_pcard1      = (state_reg == S_P1);
  assign load_dcard1      = (state_reg == S_D1);
  assign load_pcard2      = (state_reg == S_P2);
  assign load_dcard2      = (state_reg == S_D2);
  assign load_pcard3      = (state_reg == S_P3);
  assign load_dcard3      = (state_reg == S_D3);
  assign done             = (state_reg == S_DONE);
  assign player_win_light = player_light_reg;
  assign dealer_win_light = dealer_light_reg;

endmodule

// File: doc/baccarat_ctrl.md
# baccarat_ctrl

Game controller for the baccarat datapath: sequences the six card-load strobes, applies the baccarat drawing rules to the live player/dealer scores and the player's third card, and drives the win lights. It sits directly upstream of the datapath, clocked by the same slow clock. It consumes the datapath's `pscore_out`, `dscore_out` and `pcard3_out`, and produces the datapath's `load_pcard1..3` / `load_dcard1..3` inputs.

## Interface
Parameters:
- `SCORE_W`, default 4: width of the score inputs, which carry values 0–9.
- `CARD_W`, default 4: width of the card input, which carries ranks 0–13. Rank 0 means no card.

Ports:
- `slow_clock`  in  1: the only clock; all state updates on the rising edge.
- `resetb`  in  1: reset. Reset is synchronous and active-high (the polarity is fixed regardless of the name): high at an edge forces `S_IDLE`.
- `pscore`  in  SCORE_W: player score from the datapath.
- `dscore`  in  SCORE_W: dealer score from the datapath.
- `pcard3`  in  CARD_W: player third-card rank from the datapath.
- `load_pcard1`, `load_pcard2`, `load_pcard3`  out  1 each: player card load strobes.
- `load_dcard1`, `load_dcard2`, `load_dcard3`  out  1 each: dealer card load strobes.
- `player_win_light`  out  1: player wins, or tie.
- `dealer_win_light`  out  1: dealer wins, or tie.
- `done`  out  1: round complete; high while in `S_DONE`.

## Operation
- States:
  - `S_IDLE`, `S_P1`, `S_D1`, `S_P2`, `S_D2`, `S_EVAL`, `S_P3`, `S_DDEC`, `S_D3`, `S_RESULT`, `S_DONE`.
- Load strobes:
  - Moore-decoded from state; at most one is high in any cycle.
  - `S_P1`→`load_pcard1`, `S_D1`→`load_dcard1`, `S_P2`→`load_pcard2`, `S_D2`→`load_dcard2`, `S_P3`→`load_pcard3`, `S_D3`→`load_dcard3`.
- Unconditional transitions:
  - `S_IDLE`→`S_P1`→`S_D1`→`S_P2`→`S_D2`→`S_EVAL`.
  - `S_P3`→`S_DDEC`; `S_D3`→`S_RESULT`; `S_RESULT`→`S_DONE`.
  - `S_DONE` holds until reset.
- `S_EVAL`, in priority order:
  - pscore ≥ 8 or dscore ≥ 8 (natural) → `S_RESULT`.
  - pscore ≤ 5 → `S_P3`.
  - dscore ≤ 5 → `S_D3`.
  - otherwise → `S_RESULT`.
- `S_DDEC`: let v = card value of `pcard3` (rank ≥ 10 → 0, otherwise the rank). The dealer draws (→ `S_D3`, else → `S_RESULT`) when:
  - dscore ≤ 2;
  - dscore = 3 and v ≠ 8;
  - dscore = 4 and v ∈ 2..7;
  - dscore = 5 and v ∈ 4..7;
  - dscore = 6 and v ∈ 6..7;
  - never when dscore = 7.
- Lights are registered, loaded on the `S_RESULT`→`S_DONE` edge:
  - pscore > dscore: player=1, dealer=0.
  - dscore > pscore: player=0, dealer=1.
  - equal: both=1.
- Score inputs above 9 are treated as 9 everywhere.
- `pcard3` rank 0 in `S_DDEC` is treated as value 0.

## Timing
- Reset values: state `S_IDLE`; all six loads 0; both lights 0; `done` 0.
- Reset at any edge, mid-round included:
  - next cycle is `S_IDLE`;
  - loads drop that cycle;
  - lights clear that cycle.
- Reset has priority over every transition.
- The datapath captures on the same edge that leaves a load state. Updated scores and `pcard3` are therefore valid in the following state (`S_EVAL`, `S_DDEC`, `S_RESULT`), so no extra wait states are needed.
- Let k be the last edge with reset high.
  - `S_P1` at k+1 … `S_D2` at k+4; `S_EVAL` at k+5.
  - Natural or both stand: `S_RESULT` k+6; `S_DONE` and lights at k+7.
  - Player stands, dealer draws: `S_D3` k+6, `S_RESULT` k+7, `S_DONE` k+8.
  - Player draws, dealer stands: `S_P3` k+6, `S_DDEC` k+7, `S_RESULT` k+8, `S_DONE` k+9.
  - Both draw: `S_P3` k+6, `S_DDEC` k+7, `S_D3` k+8, `S_RESULT` k+9, `S_DONE` k+10 (maximum latency).
- Each strobe is exactly one cycle wide.
- `load_pcard3` and `load_dcard3` each assert at most once per round.

## Structure
- `baccarat_pkg` holds:
  - the state enum;
  - the constants `NATURAL_MIN=8` and `DRAW_MAX=5`;
  - the function `card_value(rank)` and the clamp-to-9 helper.
- One sub-module: `dealer_draw_rule`, combinational, taking (dscore, v) → draw. It is instantiated once in `baccarat_ctrl` and exhaustively testable on its own.

## Test plan
- Natural win: pscore=8, dscore=3 in `S_EVAL` → loads only `pcard1`/`dcard1`/`pcard2`/`dcard2`; at k+7 `player_win_light`=1, `dealer_win_light`=0, `done`=1.
- Both stand, tie: pscore=7, dscore=7 → no third-card strobes; both lights 1 at k+7.
- Player draws, dealer draws: pscore=4, dscore=6, `pcard3` rank 7 → `load_pcard3` at k+6, `load_dcard3` at k+8, `done` at k+10.
- Dealer rule boundaries: dscore=3 with `pcard3` rank 8 → dealer stands (`S_RESULT` k+8); dscore=3 with rank 12 (v=0) → dealer draws.
- Player stands, dealer draws: pscore=6, dscore=5 → `load_dcard3` at k+6; then dscore=9 > 6 → `dealer_win_light`=1 at k+8.
- Mid-round reset: reset asserted during `S_P3` → next cycle all loads and lights 0 in `S_IDLE`; round restarts with `load_pcard1` one cycle after reset drops.
